// File: rtl/cache_block_i_3.sv
// 4-way set-associative instruction cache, one word per block, read-only (I/S valid only).
// Misses go out on the common bus; the victim way comes from an external LRU controller.
module cache_block_i_3 #(
  parameter int ADDRESSSIZE     = 32,
  parameter int DATASIZE        = 32,
  parameter int INDEX_SIZE      = 4,
  parameter int BLK_OFFSET_SIZE = 2
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   PrRd,
  input  logic [ADDRESSSIZE-1:0] Address,
  output logic [DATASIZE-1:0]    Data_Bus,
  output logic                   Data_Ready,
  input  logic [1:0]             LRU_replacement_proc,
  output logic [1:0]             Blk_accessed,
  output logic                   BusRd,
  output logic [ADDRESSSIZE-1:0] Address_Com,
  input  logic [DATASIZE-1:0]    Data_Bus_Com,
  input  logic                   Mem_Rdy
);

  localparam int NUM_OF_SETS = 1 << INDEX_SIZE;
  localparam int NUM_WAYS    = 4;
  localparam int TAG_W       = ADDRESSSIZE - INDEX_SIZE - BLK_OFFSET_SIZE;

  typedef enum logic [1:0] {IDLE, COMPARE, MISS, RESPOND} state_t;

  state_t                                  r_state;
  logic [INDEX_SIZE-1:0]                   r_idx;
  logic [TAG_W-1:0]                        r_tag;
  logic [1:0]                              r_fill_way;
  logic [NUM_WAYS-1:0][NUM_OF_SETS-1:0]    r_valid;
  logic [TAG_W-1:0]                        r_tag_mem  [NUM_WAYS][NUM_OF_SETS];
  logic [DATASIZE-1:0]                     r_data_mem [NUM_WAYS][NUM_OF_SETS];

  logic [INDEX_SIZE-1:0] w_addr_idx;
  logic [TAG_W-1:0]      w_addr_tag;
  logic [NUM_WAYS-1:0]   w_hit_vec;
  logic [NUM_WAYS-1:0]   w_valid_set;
  logic                  w_hit;
  logic [1:0]            w_hit_way;
  logic [1:0]            w_free_way;
  logic [1:0]            w_victim;
  logic [DATASIZE-1:0]   w_hit_data;
  logic                  w_fill;
  logic                  w_unused;

  assign w_addr_idx = Address[INDEX_SIZE+BLK_OFFSET_SIZE-1:BLK_OFFSET_SIZE];
  assign w_addr_tag = Address[ADDRESSSIZE-1:INDEX_SIZE+BLK_OFFSET_SIZE];
  assign w_unused   = ^Address[BLK_OFFSET_SIZE-1:0];

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    assign w_valid_set[g] = r_valid[g][r_idx];
    assign w_hit_vec[g]   = w_valid_set[g] && (r_tag_mem[g][r_idx] == r_tag);
  end

  // Priority encoders: lowest-numbered hit way and lowest-numbered invalid way.
  always_comb begin
    w_hit_way  = 2'd0;
    w_free_way = 2'd0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (w_hit_vec[w])    w_hit_way  = 2'(w);
      if (!w_valid_set[w]) w_free_way = 2'(w);
    end
  end

  assign w_hit      = |w_hit_vec;
  assign w_victim   = (&w_valid_set) ? LRU_replacement_proc : w_free_way;
  assign w_hit_data = r_data_mem[w_hit_way][r_idx];
  assign w_fill     = (r_state == MISS) && Mem_Rdy;

  // Tag/data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_tag_mem[r_fill_way][r_idx]  <= r_tag;
      r_data_mem[r_fill_way][r_idx] <= Data_Bus_Com;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_idx        <= '0;
      r_tag        <= '0;
      r_fill_way   <= 2'd0;
      BusRd        <= 1'b0;
      Address_Com  <= '0;
      Data_Ready   <= 1'b0;
      Data_Bus     <= '0;
      Blk_accessed <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          Data_Ready <= 1'b0;
          if (PrRd) begin
            r_idx   <= w_addr_idx;
            r_tag   <= w_addr_tag;
            r_state <= COMPARE;
          end
        end
        COMPARE: begin
          if (w_hit) begin
            Data_Bus     <= w_hit_data;
            Blk_accessed <= w_hit_way;
            Data_Ready   <= 1'b1;
            r_state      <= RESPOND;
          end else begin
            r_fill_way  <= w_victim;
            BusRd       <= 1'b1;
            Address_Com <= {r_tag, r_idx, {BLK_OFFSET_SIZE{1'b0}}};
            r_state     <= MISS;
          end
        end
        MISS: begin
          if (Mem_Rdy) begin
            r_valid[r_fill_way][r_idx] <= 1'b1;
            Data_Bus     <= Data_Bus_Com;
            Blk_accessed <= r_fill_way;
            BusRd        <= 1'b0;
            Address_Com  <= '0;
            Data_Ready   <= 1'b1;
            r_state      <= RESPOND;
          end
        end
        RESPOND: begin
          Data_Ready <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_block_i_3.sv
// Scenario bench for cache_block_i_3: expected read responses are queued when a read
// is issued and retired by a monitor on every Data_Ready pulse.
module tb_cache_block_i_3;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        PrRd = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] Data_Bus;
  logic        Data_Ready;
  logic [1:0]  LRU_replacement_proc = '0;
  logic [1:0]  Blk_accessed;
  logic        BusRd;
  logic [31:0] Address_Com;
  logic [31:0] Data_Bus_Com = '0;
  logic        Mem_Rdy = 1'b0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  way;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  cache_block_i_3 #(.ADDRESSSIZE(32), .DATASIZE(32), .INDEX_SIZE(4), .BLK_OFFSET_SIZE(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .PrRd(PrRd), .Address(Address),
    .Data_Bus(Data_Bus), .Data_Ready(Data_Ready),
    .LRU_replacement_proc(LRU_replacement_proc), .Blk_accessed(Blk_accessed),
    .BusRd(BusRd), .Address_Com(Address_Com),
    .Data_Bus_Com(Data_Bus_Com), .Mem_Rdy(Mem_Rdy)
  );

  always #5 CLK = ~CLK;

  // Retire one expected response per Data_Ready pulse.
  always @(negedge CLK) begin
    exp_t e;
    if (RST_N && Data_Ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ready: got data=%h way=%0d, expected no response", Data_Bus, Blk_accessed);
      end else begin
        e = sb.pop_front();
        if ({Data_Bus, Blk_accessed} !== {e.data, e.way}) begin
          n_err++;
          $display("FAIL response: got data=%h way=%0d, expected data=%h way=%0d",
                   Data_Bus, Blk_accessed, e.data, e.way);
        end
      end
    end
  end

  task automatic test_reset();
    RST_N = 1'b0; PrRd = 1'b0; Mem_Rdy = 1'b0; Address = '0; Data_Bus_Com = '0;
    repeat (2) @(negedge CLK);
    n_vec++;
    if ({BusRd, Data_Ready} !== 2'b00) begin
      n_err++; $display("FAIL reset_ctrl: got BusRd=%b Data_Ready=%b, expected 0 0", BusRd, Data_Ready);
    end
    n_vec++;
    if (Address_Com !== 32'h0 || Data_Bus !== 32'h0) begin
      n_err++; $display("FAIL reset_bus: got Address_Com=%h Data_Bus=%h, expected 0 0", Address_Com, Data_Bus);
    end
    n_vec++;
    if (Blk_accessed !== 2'b00) begin
      n_err++; $display("FAIL reset_blk: got %b, expected 00", Blk_accessed);
    end
    RST_N = 1'b1;
  endtask

  // One complete read; the address is scrambled after the latch edge to prove it is ignored.
  task automatic do_read(input string nm, input logic [31:0] addr, input bit miss,
                         input logic [31:0] fill, input logic [1:0] lru,
                         input logic [1:0] way, input logic [31:0] data);
    @(negedge CLK);
    PrRd = 1'b1; Address = addr; LRU_replacement_proc = lru;
    sb.push_back('{data: data, way: way});
    @(negedge CLK);
    Address = addr ^ 32'hA5A5_0000;
    n_vec++;
    if (Data_Ready !== 1'b0 || BusRd !== 1'b0) begin
      n_err++; $display("FAIL %s_compare: got Data_Ready=%b BusRd=%b, expected 0 0", nm, Data_Ready, BusRd);
    end
    @(negedge CLK);
    if (miss) begin
      n_vec++;
      if (BusRd !== 1'b1 || Address_Com !== (addr & ~32'h3)) begin
        n_err++; $display("FAIL %s_busrd: got BusRd=%b Address_Com=%h, expected 1 %h", nm, BusRd, Address_Com, addr & ~32'h3);
      end
      repeat (2) @(negedge CLK);
      n_vec++;
      if (BusRd !== 1'b1 || Address_Com !== (addr & ~32'h3) || Data_Ready !== 1'b0) begin
        n_err++; $display("FAIL %s_hold: got BusRd=%b Address_Com=%h Data_Ready=%b, expected 1 %h 0",
                          nm, BusRd, Address_Com, Data_Ready, addr & ~32'h3);
      end
      Mem_Rdy = 1'b1; Data_Bus_Com = fill;
      @(negedge CLK);
      Mem_Rdy = 1'b0; Data_Bus_Com = '0;
    end
    n_vec++;
    if (Data_Ready !== 1'b1 || BusRd !== 1'b0 || Address_Com !== 32'h0) begin
      n_err++; $display("FAIL %s_respond: got Data_Ready=%b BusRd=%b Address_Com=%h, expected 1 0 0",
                        nm, Data_Ready, BusRd, Address_Com);
    end
    PrRd = 1'b0;
    @(negedge CLK);
    n_vec++;
    if (Data_Ready !== 1'b0) begin
      n_err++; $display("FAIL %s_pulse: got Data_Ready=%b after one cycle, expected 0", nm, Data_Ready);
    end
  endtask

  task automatic test_cold_and_hit();
    do_read("cold_miss", 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 2'd3, 2'd0, 32'hDEAD_BEEF);
    do_read("repeat_hit", 32'h0000_0102, 1'b0, 32'h0, 2'd3, 2'd0, 32'hDEAD_BEEF);
  endtask

  task automatic test_fill_order();
    test_reset();
    do_read("fill_w0", 32'h0000_0040, 1'b1, 32'h1000_0001, 2'd3, 2'd0, 32'h1000_0001);
    do_read("fill_w1", 32'h0000_0080, 1'b1, 32'h1000_0002, 2'd3, 2'd1, 32'h1000_0002);
    do_read("fill_w2", 32'h0000_00C0, 1'b1, 32'h1000_0003, 2'd0, 2'd2, 32'h1000_0003);
    do_read("fill_w3", 32'h0000_0100, 1'b1, 32'h1000_0004, 2'd1, 2'd3, 32'h1000_0004);
    do_read("lru_w2",  32'h0000_0140, 1'b1, 32'h1000_0005, 2'd2, 2'd2, 32'h1000_0005);
    do_read("evicted", 32'h0000_00C0, 1'b1, 32'h2000_0003, 2'd1, 2'd1, 32'h2000_0003);
    do_read("hit_w2",  32'h0000_0140, 1'b0, 32'h0, 2'd0, 2'd2, 32'h1000_0005);
    do_read("hit_w0",  32'h0000_0040, 1'b0, 32'h0, 2'd3, 2'd0, 32'h1000_0001);
  endtask

  task automatic test_stray_memrdy();
    @(negedge CLK);
    Mem_Rdy = 1'b1; Data_Bus_Com = 32'h5555_AAAA;
    @(negedge CLK);
    Mem_Rdy = 1'b0; Data_Bus_Com = '0;
    @(negedge CLK);
    n_vec++;
    if (Data_Ready !== 1'b0 || Data_Bus !== 32'h1000_0001 || Blk_accessed !== 2'd0) begin
      n_err++; $display("FAIL stray_idle: got Data_Ready=%b Data_Bus=%h Blk=%0d, expected 0 10000001 0",
                        Data_Ready, Data_Bus, Blk_accessed);
    end
    do_read("stray_then_miss", 32'h0000_0204, 1'b1, 32'h3000_0001, 2'd2, 2'd0, 32'h3000_0001);
  endtask

  task automatic test_reset_in_miss();
    @(negedge CLK);
    PrRd = 1'b1; Address = 32'h0000_0308;
    repeat (2) @(negedge CLK);
    n_vec++;
    if (BusRd !== 1'b1) begin
      n_err++; $display("FAIL rim_enter: got BusRd=%b, expected 1", BusRd);
    end
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b0; PrRd = 1'b0;
    #1;
    n_vec++;
    if (BusRd !== 1'b0 || Address_Com !== 32'h0 || Blk_accessed !== 2'd0) begin
      n_err++; $display("FAIL rim_async: got BusRd=%b Address_Com=%h Blk=%0d, expected 0 0 0", BusRd, Address_Com, Blk_accessed);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    Mem_Rdy = 1'b1; Data_Bus_Com = 32'hBAD0_BAD0;
    @(negedge CLK);
    Mem_Rdy = 1'b0; Data_Bus_Com = '0;
    repeat (3) @(negedge CLK);
    n_vec++;
    if (Data_Bus !== 32'h0 || BusRd !== 1'b0) begin
      n_err++; $display("FAIL rim_ignored: got Data_Bus=%h BusRd=%b, expected 0 0", Data_Bus, BusRd);
    end
    do_read("rim_reread", 32'h0000_0308, 1'b1, 32'h4000_0008, 2'd1, 2'd0, 32'h4000_0008);
  endtask

  task automatic test_back_to_back();
    int  gap;
    bit  seen1, seen2;
    do_read("b2b_pre0", 32'h0000_0040, 1'b1, 32'h0000_AAAA, 2'd0, 2'd0, 32'h0000_AAAA);
    do_read("b2b_pre1", 32'h0000_0080, 1'b1, 32'h0000_BBBB, 2'd0, 2'd1, 32'h0000_BBBB);
    @(negedge CLK);
    PrRd = 1'b1; Address = 32'h0000_0040;
    sb.push_back('{data: 32'h0000_AAAA, way: 2'd0});
    sb.push_back('{data: 32'h0000_BBBB, way: 2'd1});
    seen1 = 1'b0; seen2 = 1'b0; gap = 0;
    for (int k = 0; k < 10 && !seen1; k++) begin
      @(negedge CLK);
      if (Data_Ready) seen1 = 1'b1;
    end
    Address = 32'h0000_0080;
    for (int k = 0; k < 10 && !seen2; k++) begin
      @(negedge CLK);
      if (Data_Ready) seen2 = 1'b1;
      else gap++;
    end
    PrRd = 1'b0;
    n_vec++;
    if (!seen1 || !seen2 || gap < 1) begin
      n_err++; $display("FAIL b2b_pulses: got seen1=%b seen2=%b gap=%0d, expected 1 1 >=1", seen1, seen2, gap);
    end
    repeat (3) @(negedge CLK);
    n_vec++;
    if (Data_Ready !== 1'b0 || sb.size() != 0) begin
      n_err++; $display("FAIL b2b_drain: got Data_Ready=%b pending=%0d, expected 0 0", Data_Ready, sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_and_hit();
    test_fill_order();
    test_stray_memrdy();
    test_reset_in_miss();
    test_back_to_back();
    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_block_i_3.md
CACHE_BLOCK_I_3 -- requirements
Module: cache_block_I_3

Interface
REQ-001 Parameter ADDRESSSIZE, default 32, SHALL set the width of the processor and common-bus address.
REQ-002 Parameter DATASIZE, default 32, SHALL set the width of the data word (one word per block).
REQ-003 Parameter INDEX_SIZE, default 4, SHALL set the set-index width: NUM_OF_SETS = 2^INDEX_SIZE, index = Address[INDEX_SIZE+1:2].
REQ-004 Parameter BLK_OFFSET_SIZE, default 2, SHALL set the byte-offset width; tag = Address[ADDRESSSIZE-1 : INDEX_SIZE+BLK_OFFSET_SIZE].
REQ-005 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 RST_N  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 PrRd  in  1  SHALL be the processor instruction-read request, held high until Data_Ready.
REQ-008 Address  in  ADDRESSSIZE  SHALL be the processor read address, valid while PrRd is high.
REQ-009 Data_Bus  out  DATASIZE  SHALL carry the read word, valid while Data_Ready is high.
REQ-010 Data_Ready  out  1  SHALL be a one-cycle read-complete pulse.
REQ-011 LRU_replacement_proc  in  2  SHALL carry the victim way from the cache controller for the current index.
REQ-012 Blk_accessed  out  2  SHALL carry the way last hit or filled, driving the controller's LRU update.
REQ-013 BusRd  out  1  SHALL be the common-bus read request for a miss.
REQ-014 Address_Com  out  ADDRESSSIZE  SHALL carry the block-aligned miss address (offset bits zero) while BusRd is high, zero otherwise.
REQ-015 Data_Bus_Com  in  DATASIZE  SHALL carry fill data, valid when Mem_Rdy is high.
REQ-016 Mem_Rdy  in  1  SHALL be the one-cycle fill-data-valid strobe from memory.

Function
REQ-017 Storage SHALL be 4 ways x NUM_OF_SETS, each entry holding a valid bit (I/S only; no M/E), a tag and one data word.
REQ-018 The FSM SHALL have states IDLE, COMPARE, MISS and RESPOND.
REQ-019 In IDLE with PrRd high, the block SHALL latch Address and go to COMPARE; Address changes after the latch SHALL be ignored until IDLE.
REQ-020 In COMPARE, a hit SHALL be a valid way in the latched set with a matching tag; there SHALL be at most one hit way.
REQ-021 On a hit in COMPARE, the block SHALL register the way's data into Data_Bus, set Blk_accessed to the hit way and go to RESPOND.
REQ-022 On a miss in COMPARE, the block SHALL select the fill way and hold it until the fill: the lowest-numbered invalid way if any, else LRU_replacement_proc sampled in COMPARE. It SHALL then assert BusRd and Address_Com from the next cycle and go to MISS.
REQ-023 In MISS, BusRd and Address_Com SHALL stay stable until Mem_Rdy is high.
REQ-024 On Mem_Rdy in MISS, the block SHALL write Data_Bus_Com, the tag and valid=1 into the fill way, load Data_Bus with Data_Bus_Com, set Blk_accessed to the fill way, deassert BusRd next cycle and go to RESPOND.
REQ-025 In RESPOND, Data_Ready SHALL be high for exactly one cycle, then the FSM SHALL go to IDLE; PrRd SHALL be ignored in RESPOND.
REQ-026 Hit latency SHALL be Data_Ready high 2 cycles after the edge sampling PrRd; miss latency SHALL be Data_Ready high 1 cycle after the edge sampling Mem_Rdy.
REQ-027 Mem_Rdy outside MISS SHALL be ignored.
REQ-028 Blk_accessed SHALL change only on a hit or a fill, and SHALL otherwise hold its value.
REQ-029 A PrRd still high in IDLE after RESPOND SHALL start a new access (back-to-back reads permitted).

Reset
REQ-030 RST_N low SHALL immediately force IDLE, clear all valid bits, and set BusRd=0, Address_Com=0, Data_Ready=0, Data_Bus=0 and Blk_accessed=2'b00; tag and data arrays need not be cleared.
REQ-031 Reset asserted in MISS SHALL abandon the fill with no array write; after release, a Mem_Rdy SHALL be ignored.

Verification
REQ-032 Cold read 0x0000_0100 -> BusRd=1, Address_Com=0x0000_0100; Mem_Rdy with 0xDEADBEEF -> Data_Ready pulse, Data_Bus=0xDEADBEEF, Blk_accessed=0.
REQ-033 Repeat read 0x0000_0102 after REQ-032 -> no BusRd; Data_Ready 2 cycles after PrRd; Data_Bus=0xDEADBEEF; Blk_accessed=0.
REQ-034 Misses to tags 1,2,3,4 in set 0 -> fills to ways 0,1,2,3 in order; a fifth tag with LRU_replacement_proc=2 -> way 2 replaced, Blk_accessed=2, and the old way-2 tag then misses.
REQ-035 Mem_Rdy pulsed while IDLE, then PrRd to an empty set -> no fill from the stray pulse; BusRd raised normally.
REQ-036 RST_N low 3 cycles into MISS -> BusRd=0 at once; after release, Mem_Rdy -> no Data_Ready; re-read of the same address -> miss.
REQ-037 PrRd held high across two reads to 0x40 and 0x80 -> two Data_Ready pulses separated by at least one IDLE cycle, each with correct data.
